// File: rtl/instr_loader.sv
// Run-time program loader: assembles a length-prefixed, checksummed byte stream
// into 32-bit instruction words and writes them into the instruction RAM.
module instr_loader #(
  parameter int ROM_SIZE_BIT = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  // One extra index bit so a completely full image (2^ROM_SIZE_BIT words) is representable.
  localparam int          IDX_W    = ROM_SIZE_BIT + 1;
  localparam logic [31:0] CAPACITY = 32'd1 << ROM_SIZE_BIT;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state_reg, state_next;
  logic [7:0]         len_hi_reg, len_hi_next;
  logic [15:0]        len_reg, len_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [1:0]         byte_cnt_reg, byte_cnt_next;
  logic [23:0]        shift_reg, shift_next;
  logic [7:0]         sum_reg, sum_next;
  logic               wr_en_reg, wr_en_next;
  logic [31:0]        wr_addr_reg, wr_addr_next;
  logic [31:0]        wr_data_reg, wr_data_next;
  logic               busy_reg, busy_next;
  logic               hold_reg, hold_next;
  logic               done_reg, done_next;
  logic               err_reg, err_next;

  logic [IDX_W-1:0]   idx_inc;
  logic [31:0]        idx_inc_ext;
  logic [31:0]        len_ext;
  logic [31:0]        len_rx_ext;
  logic [7:0]         sum_add;

  assign idx_inc     = idx_reg + IDX_W'(1);
  assign idx_inc_ext = {{(32 - IDX_W){1'b0}}, idx_inc};
  assign len_ext     = {16'd0, len_reg};
  assign len_rx_ext  = {16'd0, len_hi_reg, rx_data};
  assign sum_add     = sum_reg + rx_data;

  always_comb begin
    state_next    = state_reg;
    len_hi_next   = len_hi_reg;
    len_next      = len_reg;
    idx_next      = idx_reg;
    byte_cnt_next = byte_cnt_reg;
    shift_next    = shift_reg;
    sum_next      = sum_reg;
    wr_en_next    = 1'b0;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    busy_next     = busy_reg;
    hold_next     = hold_reg;
    done_next     = done_reg;
    err_next      = err_reg;

    case (state_reg)
      S_IDLE, S_DONE, S_ERR: begin
        // A byte arriving together with start is deliberately dropped.
        if (start) begin
          state_next    = S_LEN_HI;
          idx_next      = '0;
          byte_cnt_next = 2'd0;
          sum_next      = 8'd0;
          busy_next     = 1'b1;
          hold_next     = 1'b1;
          done_next     = 1'b0;
          err_next      = 1'b0;
        end
      end

      S_LEN_HI: begin
        if (rx_valid) begin
          len_hi_next = rx_data;
          sum_next    = sum_add;
          state_next  = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        if (rx_valid) begin
          len_next = {len_hi_reg, rx_data};
          sum_next = sum_add;
          if (len_rx_ext > CAPACITY) begin
            state_next = S_ERR;
            busy_next  = 1'b0;
            hold_next  = 1'b1;
            err_next   = 1'b1;
          end else if (len_rx_ext == 32'd0) begin
            state_next = S_CSUM;
          end else begin
            state_next = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (rx_valid) begin
          sum_next      = sum_add;
          shift_next    = {shift_reg[15:0], rx_data};
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3) begin
            wr_en_next   = 1'b1;
            wr_data_next = {shift_reg, rx_data};
            wr_addr_next = {{(30 - IDX_W){1'b0}}, idx_reg, 2'b00};
            idx_next     = idx_inc;
            if (idx_inc_ext == len_ext) begin
              state_next = S_CSUM;
            end
          end
        end
      end

      S_CSUM: begin
        if (rx_valid) begin
          busy_next = 1'b0;
          if (rx_data == sum_reg) begin
            state_next = S_DONE;
            hold_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            // Memory may already be partially overwritten, so keep the CPU held.
            state_next = S_ERR;
            hold_next  = 1'b1;
            err_next   = 1'b1;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      len_hi_reg   <= 8'd0;
      len_reg      <= 16'd0;
      idx_reg      <= '0;
      byte_cnt_reg <= 2'd0;
      shift_reg    <= 24'd0;
      sum_reg      <= 8'd0;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= 32'd0;
      wr_data_reg  <= 32'd0;
      busy_reg     <= 1'b0;
      hold_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      len_hi_reg   <= len_hi_next;
      len_reg      <= len_next;
      idx_reg      <= idx_next;
      byte_cnt_reg <= byte_cnt_next;
      shift_reg    <= shift_next;
      sum_reg      <= sum_next;
      wr_en_reg    <= wr_en_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
      busy_reg     <= busy_next;
      hold_reg     <= hold_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

  assign wr_en    = wr_en_reg;
  assign wr_addr  = wr_addr_reg;
  assign wr_data  = wr_data_reg;
  assign busy     = busy_reg;
  assign cpu_hold = hold_reg;
  assign done     = done_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: drives byte streams on the falling edge,
// samples outputs on the falling edge, logs every instruction-memory write.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  instr_loader #(.ROM_SIZE_BIT(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en && !reset) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
      $display("write addr=0x%08h data=0x%08h", wr_addr, wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic b, input logic h,
                              input logic d, input logic e);
    check({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    check({tag, ".cpu_hold"}, {31'd0, cpu_hold}, {31'd0, h});
    check({tag, ".done"}, {31'd0, done}, {31'd0, d});
    check({tag, ".err"}, {31'd0, err}, {31'd0, e});
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic check_two_words(input string tag);
    check({tag, ".nwr"}, wa_q.size(), 32'd2);
    if (wa_q.size() == 2) begin
      check({tag, ".a0"}, wa_q[0], 32'h0000_0000);
      check({tag, ".d0"}, wd_q[0], 32'h3C01_0040);
      check({tag, ".a1"}, wa_q[1], 32'h0000_0004);
      check({tag, ".d1"}, wd_q[1], 32'h0000_0000);
    end
  endtask

  logic [7:0] two_word[11] = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h40,
                               8'h00, 8'h00, 8'h00, 8'h00, 8'h7F};
  logic [7:0] csum;
  logic [31:0] word;

  initial begin
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("rst.wr_en", {31'd0, wr_en}, 32'd0);
    check("rst.wr_addr", wr_addr, 32'd0);
    check("rst.wr_data", wr_data, 32'd0);
    check_status("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Two-word load with correct checksum
    clear_log();
    do_start();
    check_status("t1.armed", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      send(two_word[i]);
      if (i == 5) begin
        check("t1.strobe", {31'd0, wr_en}, 32'd1);
        check("t1.strobe_addr", wr_addr, 32'h0000_0000);
        check("t1.strobe_data", wr_data, 32'h3C01_0040);
      end
      if (i == 6) begin
        check("t1.strobe_off", {31'd0, wr_en}, 32'd0);
        check("t1.data_hold", wr_data, 32'h3C01_0040);
      end
    end
    check_two_words("t1");
    check_status("t1.end", 1'b0, 1'b0, 1'b1, 1'b0);

    // Bad checksum: writes still land, load ends in ERR
    clear_log();
    do_start();
    check_status("t2.armed", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) send(two_word[i]);
    send(8'h80);
    check_two_words("t2");
    check_status("t2.end", 1'b0, 1'b1, 1'b0, 1'b1);

    // Oversize length 65 > 64
    clear_log();
    do_start();
    send(8'h00);
    send(8'h41);
    check_status("t3.err", 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) send(8'h11);
    check_status("t3.trail", 1'b0, 1'b1, 1'b0, 1'b1);
    check("t3.nwr", wa_q.size(), 32'd0);

    // start with a simultaneous byte from ERR: byte dropped, then empty image
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'hFF;
    @(negedge clk);
    start = 1'b0; rx_valid = 1'b0;
    check_status("t4.armed", 1'b1, 1'b1, 1'b0, 1'b0);
    send(8'h00); send(8'h00); send(8'h00);
    check_status("t4.end", 1'b0, 1'b0, 1'b1, 1'b0);
    send(8'h00); send(8'h01); send(8'h12);
    check_status("t4.ignored", 1'b0, 1'b0, 1'b1, 1'b0);
    check("t4.nwr", wa_q.size(), 32'd0);

    // Full 64-word image, back-to-back bytes
    clear_log();
    do_start();
    csum = 8'h40;
    send(8'h00);
    send(8'h40);
    for (int w = 0; w < 64; w++) begin
      word = {w[7:0], 8'hA5, ~w[7:0], 8'h5A};
      for (int b = 3; b >= 0; b--) begin
        csum = csum + word[b*8 +: 8];
        send(word[b*8 +: 8]);
      end
    end
    check_status("t5.pre", 1'b1, 1'b1, 1'b0, 1'b0);
    send(csum);
    check("t5.nwr", wa_q.size(), 32'd64);
    for (int w = 0; w < 64 && w < wa_q.size(); w++) begin
      word = {w[7:0], 8'hA5, ~w[7:0], 8'h5A};
      check($sformatf("t5.a%0d", w), wa_q[w], 32'(w * 4));
      check($sformatf("t5.d%0d", w), wd_q[w], word);
    end
    check_status("t5.end", 1'b0, 1'b0, 1'b1, 1'b0);
    check("t5.addr_hold", wr_addr, 32'h0000_00FC);

    // Reset after two bytes of word 1
    clear_log();
    do_start();
    for (int i = 0; i < 8; i++) send(two_word[i]);
    check_status("t6.pre", 1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("t6.wr_en", {31'd0, wr_en}, 32'd0);
    check("t6.wr_addr", wr_addr, 32'd0);
    check("t6.wr_data", wr_data, 32'd0);
    check_status("t6.rst", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    send(8'h55);
    check_status("t6.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    clear_log();
    do_start();
    send(8'h00); send(8'h01);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'hAB);
    check("t6.nwr", wa_q.size(), 32'd1);
    if (wa_q.size() == 1) begin
      check("t6.a0", wa_q[0], 32'h0000_0000);
      check("t6.d0", wd_q[0], 32'h1122_3344);
    end
    check_status("t6.end", 1'b0, 1'b0, 1'b1, 1'b0);

    // start pulses while busy are ignored
    clear_log();
    do_start();
    for (int i = 0; i < 4; i++) send(two_word[i]);
    start = 1'b1;
    send(two_word[4]);
    start = 1'b0;
    send(two_word[5]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_status("t7.mid", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 6; i < 11; i++) send(two_word[i]);
    check_two_words("t7");
    check_status("t7.end", 1'b0, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
